// File: rtl/eq_coeff_bank_ctrl.sv
// ---------------------------------------------------------------------------
// eq_coeff_bank_ctrl
//
// Double-buffered coefficient store for the equalizer. The host writes into
// the shadow bank; a commit swaps shadow and active banks at the next audio
// frame boundary (channel-0 accept on the snooped equalizer input), or after
// FRAME_TIMEOUT cycles if no frame arrives. The equalizer therefore never
// filters a frame with a mix of old and new coefficients.
//
// After reset both banks are loaded with unity biquads (a0 = 1.0, the rest 0),
// one address per cycle.
//
// Optional feature (macro EQ_COEFF_COPY_EN):
//   defined   - after each swap the new active bank is copied into the new
//               shadow bank through a second read port, so the host can make
//               incremental edits. cfg_busy stays high during the copy.
//   undefined - no copy; the shadow bank holds the previously active set.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cfg_addr/cfg_d  shadow-bank write address / data
//   cfg_wr          write strobe
//   cfg_commit      request a bank swap (single-cycle pulse)
//   cfg_busy        high while initialising, waiting for a frame or copying
//   cfg_err         one-cycle pulse on a rejected write or commit
//   swap_done       one-cycle pulse in the cycle after the swap edge
//   bank_sel        index of the active bank
//   eq_coeff_addr   equalizer read address
//   eq_coeff        active-bank coefficient, registered (1-cycle latency)
//   s_eq_ch/dv/dr   snooped equalizer input channel / valid / ready
// ---------------------------------------------------------------------------
module eq_coeff_bank_ctrl #(
    parameter int NR_CHANNELS    = 3,
    parameter int NR_EQ_BANDS    = 8,
    parameter int EQ_COEFF_WIDTH = 32,
    parameter int FRAME_TIMEOUT  = 65535,
    localparam int NR_EQ_COEFF         = NR_CHANNELS * NR_EQ_BANDS * 5,
    localparam int EQ_COEFF_ADDR_WIDTH = $clog2(NR_EQ_COEFF),
    localparam int CHANNEL_WIDTH       = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [EQ_COEFF_ADDR_WIDTH-1:0] cfg_addr,
    input  logic [EQ_COEFF_WIDTH-1:0]      cfg_d,
    input  logic                           cfg_wr,
    input  logic                           cfg_commit,
    output logic                           cfg_busy,
    output logic                           cfg_err,
    output logic                           swap_done,
    output logic                           bank_sel,
    input  logic [EQ_COEFF_ADDR_WIDTH-1:0] eq_coeff_addr,
    output logic [EQ_COEFF_WIDTH-1:0]      eq_coeff,
    input  logic [CHANNEL_WIDTH-1:0]       s_eq_ch,
    input  logic                           s_eq_dv,
    input  logic                           s_eq_dr
);

    // One counter serves INIT, the frame timeout and COPY.
    localparam int CNT_MAX   = (FRAME_TIMEOUT > NR_EQ_COEFF - 1) ? FRAME_TIMEOUT : NR_EQ_COEFF - 1;
    localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

    localparam logic [CNT_WIDTH-1:0]         LAST_WORD    = CNT_WIDTH'(NR_EQ_COEFF - 1);
    localparam logic [CNT_WIDTH-1:0]         TIMEOUT      = CNT_WIDTH'(FRAME_TIMEOUT);
    localparam logic [EQ_COEFF_ADDR_WIDTH:0] NR_COEFF_EXT = (EQ_COEFF_ADDR_WIDTH + 1)'(NR_EQ_COEFF);
    localparam logic [EQ_COEFF_WIDTH-1:0]    UNITY        = EQ_COEFF_WIDTH'(1) << (EQ_COEFF_WIDTH - 4);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_WAIT_FRAME
`ifdef EQ_COEFF_COPY_EN
        , S_COPY
`endif
    } state_t;

    state_t                           r_state;
    logic [CNT_WIDTH-1:0]             r_cnt;
    logic [2:0]                       r_tap;      // position within a band (a0..b2) during INIT
    logic                             r_bank_sel;
    logic                             r_busy;
    logic                             r_err;
    logic                             r_swap_done;
    logic [EQ_COEFF_WIDTH-1:0]        r_eq_coeff;
    logic [EQ_COEFF_WIDTH-1:0]        r_bank [2][NR_EQ_COEFF];

    logic                             w_cfg_addr_ok;
    logic                             w_rd_addr_ok;
    logic                             w_in_idle;
    logic                             w_host_we;
    logic                             w_init_we;
    logic                             w_reject;
    logic                             w_frame_start;
    logic                             w_timeout;
    logic                             w_swap;
    logic [CNT_WIDTH-1:0]             w_cnt_sat_inc;
    logic [EQ_COEFF_ADDR_WIDTH-1:0]   w_word;
    logic [EQ_COEFF_WIDTH-1:0]        w_unity;

    assign w_cfg_addr_ok = {1'b0, cfg_addr} < NR_COEFF_EXT;
    assign w_rd_addr_ok  = {1'b0, eq_coeff_addr} < NR_COEFF_EXT;
    assign w_in_idle     = (r_state == S_IDLE);
    assign w_host_we     = cfg_wr & w_in_idle & w_cfg_addr_ok;
    assign w_init_we     = (r_state == S_INIT);
    assign w_reject      = (cfg_wr & ~(w_in_idle & w_cfg_addr_ok)) | (cfg_commit & ~w_in_idle);
    assign w_frame_start = s_eq_dv & s_eq_dr & (s_eq_ch == '0);

    // The timeout fires on the edge where the counter reaches FRAME_TIMEOUT,
    // i.e. exactly FRAME_TIMEOUT edges after the commit edge.
    assign w_cnt_sat_inc = (r_cnt == TIMEOUT) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout     = (w_cnt_sat_inc == TIMEOUT);
    assign w_swap        = (r_state == S_WAIT_FRAME) & (w_frame_start | w_timeout);

    assign w_word  = r_cnt[EQ_COEFF_ADDR_WIDTH-1:0];
    assign w_unity = (r_tap == 3'd0) ? UNITY : '0;

    // NOTE: the coefficient banks have no reset; INIT rewrites every word after
    // any reset, so clearing them in the reset branch would only add logic.
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_bank[0][w_word] <= w_unity;
            r_bank[1][w_word] <= w_unity;
        end else if (w_host_we) begin
            r_bank[~r_bank_sel][cfg_addr] <= cfg_d;
        end
`ifdef EQ_COEFF_COPY_EN
        else if (r_state == S_COPY) begin
            // Second read port: copy active -> shadow without touching the
            // equalizer read path below.
            r_bank[~r_bank_sel][w_word] <= r_bank[r_bank_sel][w_word];
        end
`endif
    end

    // Equalizer read port; bank_sel flips on the swap edge, so the very next
    // read already comes from the new bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eq_coeff <= '0;
        end else if (w_init_we || !w_rd_addr_ok) begin
            r_eq_coeff <= '0;
        end else begin
            r_eq_coeff <= r_bank[r_bank_sel][eq_coeff_addr];
        end
    end

    // NOTE: all state registers use non-blocking assignments so every update
    // in this block sees the pre-edge values, matching the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_tap       <= '0;
            r_bank_sel  <= 1'b0;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_err       <= w_reject;
            r_swap_done <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_tap <= (r_tap == 3'd4) ? 3'd0 : r_tap + 3'd1;
                    if (r_cnt == LAST_WORD) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (cfg_commit) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_FRAME;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT_FRAME: begin
                    if (w_swap) begin
                        r_bank_sel  <= ~r_bank_sel;
                        r_swap_done <= 1'b1;
                        r_cnt       <= '0;
`ifdef EQ_COEFF_COPY_EN
                        r_state     <= S_COPY;
`else
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
`endif
                    end else begin
                        r_cnt <= w_cnt_sat_inc;
                    end
                end
`ifdef EQ_COEFF_COPY_EN
                S_COPY: begin
                    if (r_cnt == LAST_WORD) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= S_INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign cfg_busy  = r_busy;
    assign cfg_err   = r_err;
    assign swap_done = r_swap_done;
    assign bank_sel  = r_bank_sel;
    assign eq_coeff  = r_eq_coeff;

endmodule

// File: tb/tb_eq_coeff_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_eq_coeff_bank_ctrl
//
// Scoreboard bench for eq_coeff_bank_ctrl (FRAME_TIMEOUT overridden to 100).
// The stimulus thread drives directed vectors and pushes expected read data,
// expected cfg_err cycles and expected swap events into queues; a monitor
// pops and compares whenever the DUT presents read data, cfg_err or
// swap_done. Builds with or without EQ_COEFF_COPY_EN.
// ---------------------------------------------------------------------------
module tb_eq_coeff_bank_ctrl;

    localparam int W  = 32;
    localparam int AW = 7;
    localparam int CW = 2;
    localparam int TO = 100;

    localparam logic [W-1:0] ONE     = 32'h1000_0000;
    localparam logic [W-1:0] ONE_P5  = 32'h1800_0000;
    localparam logic [W-1:0] TAP3    = 32'h0123_4567;
`ifdef EQ_COEFF_COPY_EN
    localparam logic [W-1:0] EXP_A0_AFTER_2ND = ONE_P5;
`else
    localparam logic [W-1:0] EXP_A0_AFTER_2ND = ONE;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [W-1:0]  cfg_d = '0;
    logic          cfg_wr = 1'b0;
    logic          cfg_commit = 1'b0;
    logic          cfg_busy;
    logic          cfg_err;
    logic          swap_done;
    logic          bank_sel;
    logic [AW-1:0] eq_coeff_addr = '0;
    logic [W-1:0]  eq_coeff;
    logic [CW-1:0] s_eq_ch = '0;
    logic          s_eq_dv = 1'b0;
    logic          s_eq_dr = 1'b0;

    eq_coeff_bank_ctrl #(.FRAME_TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_addr      (cfg_addr),
        .cfg_d         (cfg_d),
        .cfg_wr        (cfg_wr),
        .cfg_commit    (cfg_commit),
        .cfg_busy      (cfg_busy),
        .cfg_err       (cfg_err),
        .swap_done     (swap_done),
        .bank_sel      (bank_sel),
        .eq_coeff_addr (eq_coeff_addr),
        .eq_coeff      (eq_coeff),
        .s_eq_ch       (s_eq_ch),
        .s_eq_dv       (s_eq_dv),
        .s_eq_dr       (s_eq_dr)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rd_issue = 1'b0;
    logic rd_issue_d = 1'b0;
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        rd_issue_d <= rd_issue;
    end

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int   at_cyc;
        logic sel;
    } swap_t;

    logic [W-1:0] q_rd[$];
    int           q_err[$];
    swap_t        q_swap[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs against the queued expectations.
    always @(negedge clk) begin
        if (rd_issue_d) begin
            if (q_rd.size() == 0) check("rd_unexpected", 1, 0);
            else                  check("eq_coeff", eq_coeff, q_rd.pop_front());
        end
        if (cfg_err) begin
            if (q_err.size() == 0) check("cfg_err_unexpected", 1, 0);
            else                   check("cfg_err_cycle", cyc, q_err.pop_front());
        end
        if (swap_done) begin
            if (q_swap.size() == 0) begin
                check("swap_done_unexpected", 1, 0);
            end else begin
                swap_t s;
                s = q_swap.pop_front();
                check("swap_done_cycle", cyc, s.at_cyc);
                check("swap_bank_sel", bank_sel, s.sel);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] exp);
        eq_coeff_addr = a;
        q_rd.push_back(exp);
        rd_issue = 1'b1;
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input bit reject);
        cfg_addr = a;
        cfg_d    = d;
        cfg_wr   = 1'b1;
        if (reject) q_err.push_back(cyc + 1);
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic commit(input bit reject);
        cfg_commit = 1'b1;
        if (reject) q_err.push_back(cyc + 1);
        @(negedge clk);
        cfg_commit = 1'b0;
    endtask

    task automatic accept(input logic [CW-1:0] ch);
        s_eq_ch = ch;
        s_eq_dv = 1'b1;
        s_eq_dr = 1'b1;
        @(negedge clk);
        s_eq_dv = 1'b0;
        s_eq_dr = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (cfg_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, cfg_busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},      cfg_busy,  1);
        check({tag, "_err"},       cfg_err,   0);
        check({tag, "_swap_done"}, swap_done, 0);
        check({tag, "_bank_sel"},  bank_sel,  0);
        check({tag, "_eq_coeff"},  eq_coeff,  0);
    endtask

    initial begin
        int c;
        int n;

        // Reset state and INIT duration.
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        rd(0, '0);                       // read during INIT returns 0
        n = 1;
        while (cfg_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("init_busy_cycles", n, 120);

        // Unity contents and out-of-range read.
        rd(0,   ONE);
        rd(5,   ONE);
        rd(115, ONE);
        rd(1,   '0);
        rd(119, '0);
        rd(120, '0);

        // Commit swapped by a channel-0 accept 37 cycles after the commit.
        wr(0, ONE_P5, 0);
        c = cyc;
        q_swap.push_back('{c + 38, 1'b1});
        commit(0);
        wait_cyc(c + 10);
        accept(1);                       // channel 1 is not a frame boundary
        wait_cyc(c + 20);
        wr(2, 32'hDEAD_BEEF, 1);         // write during WAIT_FRAME is rejected
        check("busy_in_wait_frame", cfg_busy, 1);
        check("bank_sel_before_swap", bank_sel, 0);
        wait_cyc(c + 25);
        commit(1);                       // commit during WAIT_FRAME is rejected
        wait_cyc(c + 37);
        accept(0);
        rd(0, ONE_P5);
        rd(2, '0);
        rd(5, ONE);
        wait_idle("idle_after_frame_swap");

        // Rejected out-of-range write, one incremental write, timeout swap.
        wr(120, 32'h1234_5678, 1);
        wr(3, TAP3, 0);
        c = cyc;
        q_swap.push_back('{c + 101, 1'b0});
        commit(0);
        wait_cyc(c + 101);
        rd(3,   TAP3);
        rd(0,   EXP_A0_AFTER_2ND);
        rd(120, '0);
        wait_idle("idle_after_timeout_swap");

        // Reset shortly after a swap (inside COPY when the copy is built in).
        wr(0, 32'h7FFF_FFFF, 0);
        c = cyc;
        q_swap.push_back('{c + 6, 1'b1});
        commit(0);
        wait_cyc(c + 5);
        accept(0);
        wait_cyc(c + 40);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("idle_after_reinit");
        check("bank_sel_after_reinit", bank_sel, 0);
        rd(0,  ONE);
        rd(3,  '0);
        rd(4,  '0);
        rd(10, ONE);

        // A commit pending at reset must be discarded.
        c = cyc;
        commit(0);
        wait_cyc(c + 10);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("idle_after_discard");
        wait_cyc(cyc + 150);
        check("bank_sel_after_discard", bank_sel, 0);
        rd(0, ONE);

        repeat (3) @(negedge clk);
        check("rd_queue_empty",   q_rd.size(),   0);
        check("err_queue_empty",  q_err.size(),  0);
        check("swap_queue_empty", q_swap.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eq_coeff_bank_ctrl.md
Name: eq_coeff_bank_ctrl

Overview:
- Double-buffered coefficient store and swap controller for the equalizer's coefficient read port (eq_coeff_addr -> eq_coeff, 1-cycle registered read).
- Host writes go to a shadow bank; a commit request swaps shadow and active atomically at an audio frame boundary, so no frame is filtered with mixed coefficient sets.
- Sits between the host configuration interface and the equalizer; snoops the equalizer's input handshake to detect frame starts.

Parameters:
- NR_CHANNELS, 3, audio channels per frame
- NR_EQ_BANDS, 8, biquad bands per channel
- EQ_COEFF_WIDTH, 32, coefficient width, signed fixed point, range (-8.0, 8.0), 1.0 = 1 << (EQ_COEFF_WIDTH-4)
- FRAME_TIMEOUT, 65535, cycles to wait for a frame boundary before forcing the swap
- Derived: NR_EQ_COEFF = NR_CHANNELS*NR_EQ_BANDS*5 (order a0,a1,a2,b1,b2 per band); EQ_COEFF_ADDR_WIDTH = $clog2(NR_EQ_COEFF); CHANNEL_WIDTH = $clog2(NR_CHANNELS)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_addr  in  EQ_COEFF_ADDR_WIDTH  shadow-bank write address
- cfg_d  in  EQ_COEFF_WIDTH  shadow-bank write data
- cfg_wr  in  1  write strobe
- cfg_commit  in  1  request bank swap (single-cycle pulse)
- cfg_busy  out  1  high in INIT, WAIT_FRAME and COPY
- cfg_err  out  1  one-cycle pulse on a rejected write or commit
- swap_done  out  1  one-cycle pulse, cycle after the swap
- bank_sel  out  1  index of the active bank
- eq_coeff_addr  in  EQ_COEFF_ADDR_WIDTH  equalizer coefficient read address
- eq_coeff  out  EQ_COEFF_WIDTH  active-bank coefficient, registered
- s_eq_ch  in  CHANNEL_WIDTH  snooped equalizer input channel
- s_eq_dv  in  1  snooped equalizer input valid
- s_eq_dr  in  1  snooped equalizer input ready

Behaviour:
- Reset values: cfg_busy=1, cfg_err=0, swap_done=0, bank_sel=0, eq_coeff=0; state=INIT, counter=0.
- Read path: eq_coeff <= active[eq_coeff_addr] every cycle, 1-cycle latency. An address >= NR_EQ_COEFF returns 0. In INIT, eq_coeff returns 0.
- Frame boundary: the cycle in which s_eq_dv & s_eq_dr & (s_eq_ch==0).
- INIT:
  - Writes unity to both banks, one address per cycle, counter 0..NR_EQ_COEFF-1 (NR_EQ_COEFF cycles).
  - Unity means a0 = 1 << (EQ_COEFF_WIDTH-4); a1, a2, b1, b2 = 0.
  - Then goes to IDLE with cfg_busy=0.
- IDLE:
  - cfg_wr with a valid address writes shadow[cfg_addr].
  - cfg_commit goes to WAIT_FRAME and clears the timeout counter.
  - cfg_wr and cfg_commit in the same cycle: the write is performed and included in the commit.
- WAIT_FRAME:
  - On a frame boundary or when the timeout counter reaches FRAME_TIMEOUT: bank_sel toggles at that edge, so the read in the next cycle comes from the new bank.
  - swap_done pulses the following cycle.
  - Next state is COPY when the feature is enabled, otherwise IDLE.
  - The timeout counter saturates.
- COPY (feature only):
  - Copies new active bank to new shadow bank, one word per cycle, NR_EQ_COEFF cycles.
  - Uses a second read port, so the equalizer read path is not stalled.
  - Then goes to IDLE.
- Rejections (each pulses cfg_err for one cycle, no state change):
  - cfg_wr in any state other than IDLE;
  - cfg_wr with cfg_addr >= NR_EQ_COEFF;
  - cfg_commit when not in IDLE.
- Reset mid-operation, any state: returns to reset values and INIT; both banks are reinitialised to unity; a pending swap is discarded.
- Counters are sized for NR_EQ_COEFF and FRAME_TIMEOUT; no wrap in normal operation.

Optional Feature:
- Macro EQ_COEFF_COPY_EN.
- Defined: COPY state present; after a swap the shadow bank equals the active bank, so the host may update individual coefficients incrementally. cfg_busy is held NR_EQ_COEFF cycles longer.
- Undefined: no COPY state and no second read port; after a swap the shadow holds the previous active set, and the host must rewrite every coefficient it needs before the next commit.

Test Plan:
- Reset release -> cfg_busy high for 120 cycles (defaults); reads of address 0, 5 and 115 return 0x10000000 and address 1 returns 0. Address 120 returns 0.
- Write a0 of address 0 = 0x18000000 (1.5), then commit; drive a channel-0 accept 37 cycles later -> bank_sel toggles at that edge, swap_done pulses the next cycle, and a read of address 0 in the following cycle returns 0x18000000.
- Commit with s_eq_dv held low, FRAME_TIMEOUT=100 -> swap occurs exactly 100 cycles after commit, then swap_done pulses.
- Write during WAIT_FRAME, and write to address 120 in IDLE -> cfg_err pulses each time; active and shadow banks unchanged.
- With EQ_COEFF_COPY_EN: after a swap, write only address 3, then commit -> all other addresses keep the values from the previous commit. Without the macro: the same sequence shows unity/previous contents from the older bank.
- Assert rst_n low in the middle of COPY, then release -> bank_sel=0, INIT runs again and all reads return unity values.
